// File: rtl/root_pkg.sv
// root_pkg: shared types and widths for the Root engine dispatcher.
//   state_t - dispatcher FSM states
//   job_t   - one buffered root request {radicand, degree, tag}
package root_pkg;
   localparam int RAD_W = 10;
   localparam int DEG_W = 3;
   localparam int RES_W = 20;
   localparam int TAG_W = 2;
   localparam int JOB_W = RAD_W + DEG_W + TAG_W;
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, HOLD, DRAIN} state_t;
   typedef struct packed {
      logic [RAD_W-1:0] radicand;
      logic [DEG_W-1:0] degree;
      logic [TAG_W-1:0] tag;
   } job_t;
endpackage

// File: rtl/root_req_fifo.sv
// root_req_fifo: synchronous FIFO of packed jobs, head visible on dout.
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push, din - write din when push
//   pop       - drop the head entry
//   dout      - current head entry
//   full      - no free entry
//   empty     - no valid entry
module root_req_fifo
   import root_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [JOB_W-1:0] din,
   output logic [JOB_W-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wptr, rptr;
   logic [JOB_W-1:0] mem [DEPTH];
   logic             wen;
   // The extra pointer bit separates full (bits differ) from empty (bits equal).
   assign empty = wptr == rptr;
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];
   // A write into a full FIFO is only legal when the head leaves in the same cycle.
   assign wen   = push && (!full || pop);
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wen) wptr <= wptr + (AW+1)'(1);
         if (pop && !empty) rptr <= rptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (wen) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/root_job_dispatcher.sv
// root_job_dispatcher: buffers root requests and feeds them one at a time to the Root engine.
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/ready              - request handshake; req_radicand, req_degree, req_tag
//   eng_in_valid, eng_in_data_1/2 - engine launch (pulse held LAUNCH_CYCLES, data held for the job)
//   eng_out_valid, eng_out_data  - engine result (valid high for two cycles)
//   resp_valid/ready             - response handshake; resp_data, resp_tag, resp_err
//   fault                        - sticky watchdog timeout flag, cleared only by rst
module root_job_dispatcher
   import root_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int LAUNCH_CYCLES = 2,
   parameter int WDOG_LIMIT    = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [RAD_W-1:0] req_radicand,
   input  logic [DEG_W-1:0] req_degree,
   input  logic [TAG_W-1:0] req_tag,
   output logic             eng_in_valid,
   output logic [RAD_W-1:0] eng_in_data_1,
   output logic [DEG_W-1:0] eng_in_data_2,
   input  logic             eng_out_valid,
   input  logic [RES_W-1:0] eng_out_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [RES_W-1:0] resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic             fault
);
   localparam int LW = $clog2(LAUNCH_CYCLES + 1);
   localparam int WW = $clog2(WDOG_LIMIT + 1);
   state_t           state, nxt;
   logic [JOB_W-1:0] head_w;
   job_t             head;
   logic             full, empty, push, pop, hit, tmo;
   logic             rdy_q, ov_q, fault_q, rerr_q;
   logic [LW-1:0]    lcnt;
   logic [WW-1:0]    wdog;
   logic [RAD_W-1:0] d1_q;
   logic [DEG_W-1:0] d2_q;
   logic [RES_W-1:0] rdata_q;
   logic [TAG_W-1:0] rtag_q;
   assign head = job_t'(head_w);
   // rdy_q keeps req_ready low through reset and for the cycle rst falls.
   assign req_ready     = rdy_q && !full && !fault_q;
   assign push          = req_valid && req_ready;
   assign eng_in_valid  = state == LAUNCH;
   assign eng_in_data_1 = d1_q;
   assign eng_in_data_2 = d2_q;
   assign resp_valid    = state == HOLD;
   assign resp_data     = rdata_q;
   assign resp_tag      = rtag_q;
   assign resp_err      = rerr_q;
   assign fault         = fault_q;
   root_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({req_radicand, req_degree, req_tag}),
      .dout  (head_w),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      nxt = state;
      pop = 1'b0;
      hit = 1'b0;
      tmo = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !fault_q) begin
               pop = 1'b1;
               nxt = (head.degree == '0) ? HOLD : LAUNCH;
            end
         end
         LAUNCH: if (lcnt == LW'(LAUNCH_CYCLES - 1)) nxt = WAIT;
         WAIT: begin
            // Only the rising edge counts; the engine's second valid cycle lands in HOLD.
            if (eng_out_valid && !ov_q) begin
               hit = 1'b1;
               nxt = HOLD;
            end else if (wdog == WW'(WDOG_LIMIT - 1)) begin
               tmo = 1'b1;
               nxt = HOLD;
            end
         end
         HOLD: if (resp_ready) nxt = DRAIN;
         // One quiet cycle of eng_out_valid means the engine is back in init.
         DRAIN: if (!eng_out_valid) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rdy_q   <= 1'b0;
         ov_q    <= 1'b0;
         fault_q <= 1'b0;
         lcnt    <= '0;
         wdog    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         rdata_q <= '0;
         rtag_q  <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state <= nxt;
         rdy_q <= 1'b1;
         ov_q  <= eng_out_valid;
         lcnt  <= (state == LAUNCH) ? lcnt + LW'(1) : '0;
         wdog  <= (state == WAIT) ? wdog + WW'(1) : '0;
         if (pop) begin
            d1_q    <= head.radicand;
            d2_q    <= head.degree;
            rtag_q  <= head.tag;
            rerr_q  <= head.degree == '0;
            rdata_q <= '0;
         end
         if (hit) rdata_q <= eng_out_data;
         if (tmo) begin
            rdata_q <= '0;
            rerr_q  <= 1'b1;
            fault_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_root_job_dispatcher.sv
// tb_root_job_dispatcher: directed bench with an engine model and an in-order response scoreboard.
module tb_root_job_dispatcher;
   import root_pkg::*;
   localparam int LAUNCH_CYCLES = 2;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0, req_ready;
   logic [RAD_W-1:0] req_radicand = '0;
   logic [DEG_W-1:0] req_degree = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             eng_in_valid;
   logic [RAD_W-1:0] eng_in_data_1;
   logic [DEG_W-1:0] eng_in_data_2;
   logic             eng_out_valid = 1'b0;
   logic [RES_W-1:0] eng_out_data = '0;
   logic             resp_valid, resp_ready = 1'b1;
   logic [RES_W-1:0] resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_err, fault;
   always #5 clk = ~clk;
   root_job_dispatcher dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_radicand(req_radicand), .req_degree(req_degree), .req_tag(req_tag),
      .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1), .eng_in_data_2(eng_in_data_2),
      .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err), .fault(fault)
   );
   typedef struct {int rad; int deg; int tag;} exp_t;
   exp_t q[$];
   exp_t j;
   int   vec = 0, miss = 0, cyc = 0;
   int   lat = 5;
   logic dead = 1'b0;
   int   e_t = 0, e_rad = 0, e_deg = 0, run = 0;
   logic e_busy = 1'b0, ein_prev = 1'b0, rv_prev = 1'b0, fault_prev = 1'b0;
   int   n_launch = 0, n_resp = 0, launch_cyc = 0, launch_end_cyc = 0;
   int   last_ov_cyc = -100, hold_cyc = 0, fault_cyc = 0, hs_cyc = 0;
   int   last_data = 0, last_tag = 0, last_err = 0;
   int   xe, xd;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic int eng_result(input int r, input int d);
      if (d == 0) return 0;
      return $rtoi($floor($pow(real'(r), 1.0 / real'(d)) * 1024.0 + 1.0e-6));
   endfunction
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vec++;
      if (a !== e) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // Engine model plus per-cycle protocol and scoreboard checks, all at mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         e_busy = 1'b0;
         e_t = 0;
         eng_out_valid = 1'b0;
         ein_prev = 1'b0;
         rv_prev = 1'b0;
         fault_prev = 1'b0;
         run = 0;
      end else begin
         if (eng_in_valid && !ein_prev) begin
            chk("engine_idle_at_launch", 32'(e_busy), 0);
            chk("launch_gap", 32'((cyc - last_ov_cyc) >= 3), 1);
            n_launch++;
            launch_cyc = cyc;
            e_busy = 1'b1;
            e_t = 0;
            e_rad = int'(eng_in_data_1);
            e_deg = int'(eng_in_data_2);
         end else if (e_busy) e_t++;
         if (eng_in_valid) begin
            run++;
            launch_end_cyc = cyc;
            chk("launch_has_job", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               chk("eng_data_1", 32'(eng_in_data_1), 32'(q[0].rad));
               chk("eng_data_2", 32'(eng_in_data_2), 32'(q[0].deg));
            end
         end else if (run != 0) begin
            chk("launch_len", 32'(run), LAUNCH_CYCLES);
            run = 0;
         end
         eng_out_valid = e_busy && !dead && (e_t == lat || e_t == lat + 1);
         eng_out_data = RES_W'(eng_result(e_rad, e_deg));
         if (eng_out_valid) last_ov_cyc = cyc;
         if (e_busy && !dead && e_t >= lat + 1) e_busy = 1'b0;
         if (resp_valid) begin
            chk("hold_no_launch", 32'(eng_in_valid), 0);
            chk("resp_has_job", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               j = q[0];
               xe = (j.deg == 0 || dead) ? 1 : 0;
               xd = xe ? 0 : eng_result(j.rad, j.deg);
               chk("resp_tag", 32'(resp_tag), 32'(j.tag));
               chk("resp_err", 32'(resp_err), 32'(xe));
               chk("resp_data", 32'(resp_data), 32'(xd));
               if (resp_ready) begin
                  void'(q.pop_front());
                  n_resp++;
                  last_data = int'(resp_data);
                  last_tag = int'(resp_tag);
                  last_err = int'(resp_err);
               end
            end
            if (!rv_prev) hold_cyc = cyc;
         end
         if (fault) chk("fault_blocks_ready", 32'(req_ready), 0);
         if (fault && !fault_prev) fault_cyc = cyc;
         if (req_valid && req_ready)
            q.push_back('{int'(req_radicand), int'(req_degree), int'(req_tag)});
         ein_prev = eng_in_valid;
         rv_prev = resp_valid;
         fault_prev = fault;
      end
   end
   task automatic send(input int r, input int d, input int t);
      int k;
      k = 0;
      req_radicand = RAD_W'(r);
      req_degree = DEG_W'(d);
      req_tag = TAG_W'(t);
      req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("req_accept", 32'(req_ready), 1);
      hs_cyc = cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask
   task automatic wait_resps(input int target);
      int k;
      k = 0;
      while (n_resp < target && k < 600) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 chk("resp_count", 32'(n_resp), 32'(target));
   endtask
   task automatic check_zero(input string p);
      chk({p, "_req_ready"}, 32'(req_ready), 0);
      chk({p, "_eng_in_valid"}, 32'(eng_in_valid), 0);
      chk({p, "_eng_in_data_1"}, 32'(eng_in_data_1), 0);
      chk({p, "_eng_in_data_2"}, 32'(eng_in_data_2), 0);
      chk({p, "_resp_valid"}, 32'(resp_valid), 0);
      chk({p, "_resp_data"}, 32'(resp_data), 0);
      chk({p, "_resp_tag"}, 32'(resp_tag), 0);
      chk({p, "_resp_err"}, 32'(resp_err), 0);
      chk({p, "_fault"}, 32'(fault), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end
   initial begin
      int base, nl, k;
      chk("model_sqrt16", 32'(eng_result(16, 2)), 32'h01000);
      chk("model_deg1", 32'(eng_result(7, 1)), 32'(7 * 1024));
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst = 1'b0;
      chk("ready_low_rst_fall", 32'(req_ready), 0);
      @(posedge clk);
      #1 chk("ready_rises", 32'(req_ready), 1);
      // single job
      base = n_resp;
      send(16, 2, 1);
      wait_resps(base + 1);
      chk("single_launch_latency", 32'(launch_cyc - hs_cyc), 2);
      chk("single_data", 32'(last_data), 32'h01000);
      chk("single_tag", 32'(last_tag), 1);
      chk("single_err", 32'(last_err), 0);
      // degree zero
      base = n_resp;
      nl = n_launch;
      send(9, 0, 3);
      wait_resps(base + 1);
      chk("deg0_hold_latency", 32'(hold_cyc - hs_cyc), 2);
      chk("deg0_no_launch", 32'(n_launch), 32'(nl));
      chk("deg0_tag", 32'(last_tag), 3);
      chk("deg0_err", 32'(last_err), 1);
      chk("deg0_data", 32'(last_data), 0);
      // burst of five, consumer always ready
      base = n_resp;
      send(25, 2, 0);
      send(1000, 3, 1);
      send(7, 1, 2);
      send(625, 4, 3);
      send(50, 5, 0);
      chk("burst_full_ready", 32'(req_ready), 0);
      wait_resps(base + 5);
      chk("burst_last_tag", 32'(last_tag), 0);
      // backpressure
      resp_ready = 1'b0;
      base = n_resp;
      send(144, 2, 2);
      send(343, 3, 1);
      k = 0;
      while (!resp_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      nl = n_launch;
      repeat (50) @(negedge clk);
      chk("bp_still_valid", 32'(resp_valid), 1);
      chk("bp_no_relaunch", 32'(n_launch), 32'(nl));
      @(posedge clk);
      #1 resp_ready = 1'b1;
      wait_resps(base + 2);
      chk("bp_second_tag", 32'(last_tag), 1);
      // watchdog
      dead = 1'b1;
      base = n_resp;
      send(200, 2, 2);
      k = 0;
      while (!fault && k < 300) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 chk("wdog_fired", 32'(fault), 1);
      chk("wdog_latency", 32'(fault_cyc - launch_end_cyc), 97);
      chk("wdog_ready_low", 32'(req_ready), 0);
      wait_resps(base + 1);
      chk("wdog_err", 32'(last_err), 1);
      chk("wdog_data", 32'(last_data), 0);
      rst = 1'b1;
      dead = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero("wdog_rst");
      rst = 1'b0;
      @(posedge clk);
      #1 base = n_resp;
      send(64, 3, 1);
      wait_resps(base + 1);
      chk("recover_err", 32'(last_err), 0);
      // reset mid-WAIT with three jobs queued
      lat = 40;
      send(100, 2, 0);
      send(101, 2, 1);
      send(102, 2, 2);
      send(103, 2, 3);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 check_zero("mid_rst");
      rst = 1'b0;
      lat = 5;
      nl = n_launch;
      base = n_resp;
      repeat (20) @(posedge clk);
      #1 chk("mid_rst_no_launch", 32'(n_launch), 32'(nl));
      chk("mid_rst_no_resp", 32'(n_resp), 32'(base));
      send(27, 3, 0);
      wait_resps(base + 1);
      chk("post_rst_tag", 32'(last_tag), 0);
      chk("post_rst_err", 32'(last_err), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
